shift_seq_ctrl: RTL and testbench
=================================

# shift_seq_ctrl

Sequencer for a WIDTH-bit serial shift register, sitting between a parallel producer/consumer and a serial link.
- Accepts a parallel word over a valid/ready handshake.
- Shifts the word out serially for exactly WIDTH cycles while capturing WIDTH serial input bits into the same register.
- Presents the captured word on a held valid/ready output.
- Owns the register, bit counter and state machine, so upstream logic never times the shifts itself.

## Interface
- WIDTH, 4, shift register and word width in bits; legal range 2..32.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  block can accept a word; high only in IDLE and only while rst is low.
- in_data  input  WIDTH  parallel word to transmit.
- sin  input  1  serial input bit, sampled on every SHIFT-cycle edge.
- sout  output  1  serial output bit; 0 outside SHIFT.
- shift_en  output  1  high exactly during SHIFT cycles; framing strobe for the serial link.
- out_valid  output  1  captured word available; high only in DONE.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  WIDTH  captured word; equals the shift register contents.

## Operation
- State register holds one of three states: IDLE, SHIFT, DONE. Internal registers:
  - sreg[WIDTH-1:0]
  - cnt[$clog2(WIDTH)-1:0]
- Reset: state IDLE, sreg 0, cnt 0. Reset takes priority over every other event, including a reset mid-SHIFT or mid-DONE. Nothing in flight is preserved.
- Output values while in reset and in IDLE after reset: in_ready 0 while rst is high, then 1 in IDLE; sout 0; shift_en 0; out_valid 0; out_data 0.
- IDLE: on in_valid && in_ready, load sreg <= in_data, cnt <= 0, go to SHIFT. Otherwise hold.
- SHIFT:
  - sout = sreg[0]; shift_en = 1.
  - Each edge: sreg <= {sin, sreg[WIDTH-1:1]}, cnt <= cnt+1.
  - On the edge where cnt == WIDTH-1, go to DONE and clear cnt.
  - in_valid is ignored.
- DONE:
  - out_valid = 1, out_data = sreg, held stable.
  - On out_valid && out_ready, go to IDLE.
  - in_ready stays 0, so no accept overlaps DONE.
- Bit ordering (default, LSB-first):
  - in_data[i] appears on sout in the i-th SHIFT cycle (0-based).
  - sin sampled in the i-th SHIFT cycle lands in out_data[i].
- Loopback (sin tied to sout) returns out_data == in_data.
- cnt never wraps. It counts 0..WIDTH-1 only within SHIFT.
- out_data is stale during SHIFT (partially shifted contents). It is defined only while out_valid is high.

## Timing
- Accept edge E0: in_valid && in_ready sampled high.
- SHIFT occupies cycles E0+1 .. E0+WIDTH; shift_en is high for exactly WIDTH consecutive cycles.
- out_valid rises in cycle E0+WIDTH+1.
- With out_ready held 1, DONE lasts one cycle and IDLE is re-entered at E0+WIDTH+2. Minimum accept-to-accept period is WIDTH+2 cycles.
- out_ready low: DONE is held indefinitely with out_data stable; in_ready stays 0.
- rst asserted at any edge: IDLE in the following cycle with all outputs at reset values; in_ready 1 once rst is low.
- in_ready, out_valid and shift_en are pure functions of state (and rst for in_ready). No combinational path from in_valid or out_ready to any output.

## Configuration
- Macro: SHIFT_SEQ_MSB_FIRST_EN.
- Defined (MSB-first):
  - sout = sreg[WIDTH-1].
  - Shift is sreg <= {sreg[WIDTH-2:0], sin}.
  - in_data[WIDTH-1-i] is driven in SHIFT cycle i.
  - sin from SHIFT cycle i lands in out_data[WIDTH-1-i].
- Undefined: LSB-first behaviour as in Operation.
- Loopback identity and all cycle timing are identical in both builds.

## Test plan
- Loopback, WIDTH=4, in_data 4'b1011, out_ready 1:
  - sout is 1,1,0,1 over 4 shift_en cycles.
  - out_valid for 1 cycle with out_data 4'b1011.
  - in_ready high again 6 cycles after the accept edge.
- Independent serial input: in_data 4'b0000, sin driven 0,0,1,1 in SHIFT cycles 0..3 -> out_data 4'b1100 (LSB-first); 4'b0011 with SHIFT_SEQ_MSB_FIRST_EN.
- Backpressure: out_ready low for 3 cycles after out_valid rises; in_valid held high with a second word throughout.
  - out_valid and out_data hold; in_ready stays 0.
  - The second word is accepted only in the first IDLE cycle after the out_ready handshake.
- Reset mid-operation: rst pulsed in SHIFT cycle 2 -> next cycle shift_en 0, sout 0, out_valid 0, in_ready 1 (rst low). No out_valid ever appears for the aborted word.
- Back-to-back: in_valid and out_ready tied high, words 4'hA and 4'h5 with loopback -> accepts exactly every 6 cycles; out_data sequence A, 5.
- MSB-first build, loopback 4'b1011 -> sout 1,0,1,1; out_data 4'b1011.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// Serial shift-register sequencer: accept a parallel word, shift it out for WIDTH cycles
// while capturing sin, then hold the captured word. Define SHIFT_SEQ_MSB_FIRST_EN for MSB-first.
module shift_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             sin,
    output logic             sout,
    output logic             shift_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sreg;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] w_sreg_shifted;
    logic             w_sout_bit;
    logic             w_accept;
    logic             w_last;

`ifdef SHIFT_SEQ_MSB_FIRST_EN
    assign w_sreg_shifted = {r_sreg[WIDTH-2:0], sin};
    assign w_sout_bit     = r_sreg[WIDTH-1];
`else
    assign w_sreg_shifted = {sin, r_sreg[WIDTH-1:1]};
    assign w_sout_bit     = r_sreg[0];
`endif

    // Handshake outputs depend on state only (in_ready also masked by rst).
    assign in_ready  = (r_state == IDLE) && !rst;
    assign shift_en  = (r_state == SHIFT);
    assign out_valid = (r_state == DONE);
    assign sout      = shift_en ? w_sout_bit : 1'b0;
    assign out_data  = r_sreg;

    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_cnt == CNT_LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = SHIFT;
            SHIFT:   if (w_last) w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sreg  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_sreg <= in_data;
                        r_cnt  <= '0;
                    end
                end
                SHIFT: begin
                    r_sreg <= w_sreg_shifted;
                    r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed self-checking bench for shift_seq_ctrl (WIDTH=4), covering both bit orders
// via SHIFT_SEQ_MSB_FIRST_EN.
module tb_shift_seq_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         sin = 1'b0;
    logic         sout;
    logic         shift_en;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_data;

    int n_checks = 0;
    int n_errors = 0;
    bit lb = 1'b0;

    shift_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sin       (sin),
        .sout      (sout),
        .shift_en  (shift_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle; in loopback mode sin follows sout.
    task automatic tick();
        @(posedge clk);
        #1;
        if (lb) sin = sout;
    endtask

    logic [W-1:0] exp_sout_1011;
    logic [W-1:0] exp_indep;
    logic [3:0]   sin_vec;

    initial begin
`ifdef SHIFT_SEQ_MSB_FIRST_EN
        exp_sout_1011 = 4'b1101; // bit i = sout in shift cycle i: 1,0,1,1
        exp_indep     = 4'b0011;
`else
        exp_sout_1011 = 4'b1011; // 1,1,0,1
        exp_indep     = 4'b1100;
`endif
        sin_vec = 4'b1100;       // bit i = sin in shift cycle i: 0,0,1,1

        // Reset state
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_sout", sout, 0);
        check("rst_shift_en", shift_en, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", in_ready, 1);

        // Loopback 1011
        lb = 1'b1;
        in_data = 4'b1011;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            check($sformatf("lb_shift_en%0d", i), shift_en, 1);
            check($sformatf("lb_sout%0d", i), sout, exp_sout_1011[i]);
            check($sformatf("lb_in_ready%0d", i), in_ready, 0);
            tick();
        end
        check("lb_shift_en_off", shift_en, 0);
        check("lb_out_valid", out_valid, 1);
        check("lb_out_data", out_data, 4'b1011);
        check("lb_done_in_ready", in_ready, 0);
        tick();
        check("lb_out_valid_1cyc", out_valid, 0);
        check("lb_in_ready_e6", in_ready, 1);

        // Independent serial input
        lb = 1'b0;
        in_data = 4'b0000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            sin = sin_vec[i];
            tick();
        end
        check("ind_out_valid", out_valid, 1);
        check("ind_out_data", out_data, exp_indep);
        tick();

        // Backpressure with a second word waiting
        lb = 1'b1;
        out_ready = 1'b0;
        in_data = 4'h6;
        in_valid = 1'b1;
        tick();
        in_data = 4'h9;
        for (int i = 0; i < W; i++) tick();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp_out_valid%0d", k), out_valid, 1);
            check($sformatf("bp_out_data%0d", k), out_data, 4'h6);
            check($sformatf("bp_in_ready%0d", k), in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        check("bp_out_valid3", out_valid, 1);
        check("bp_out_data3", out_data, 4'h6);
        tick();
        check("bp_idle_in_ready", in_ready, 1);
        check("bp_idle_shift_en", shift_en, 0);
        tick();
        in_valid = 1'b0;
        check("bp_second_accepted", shift_en, 1);
        for (int i = 0; i < W; i++) tick();
        check("bp_second_out_valid", out_valid, 1);
        check("bp_second_out_data", out_data, 4'h9);
        tick();

        // Reset in SHIFT cycle 2
        in_data = 4'hF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("rm_in_shift2", shift_en, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rm_shift_en", shift_en, 0);
        check("rm_sout", sout, 0);
        check("rm_out_valid", out_valid, 0);
        check("rm_out_data", out_data, 0);
        #1;
        check("rm_in_ready", in_ready, 1);
        begin
            int seen = 0;
            for (int c = 0; c < 8; c++) begin
                if (out_valid) seen++;
                tick();
            end
            check("rm_no_out_valid", seen, 0);
        end

        // Back-to-back A then 5
        begin
            int acc_cyc[$];
            logic [W-1:0] outs[$];
            int n_acc = 0;
            bit acc_now;
            in_data = 4'hA;
            in_valid = 1'b1;
            out_ready = 1'b1;
            for (int c = 0; c < 16; c++) begin
                acc_now = in_valid && in_ready;
                if (out_valid) outs.push_back(out_data);
                if (acc_now) acc_cyc.push_back(c);
                tick();
                if (acc_now) begin
                    n_acc++;
                    if (n_acc == 1) in_data = 4'h5;
                    if (n_acc == 2) in_valid = 1'b0;
                end
            end
            check("b2b_accepts", acc_cyc.size(), 2);
            if (acc_cyc.size() == 2) check("b2b_period", acc_cyc[1] - acc_cyc[0], 6);
            check("b2b_outs", outs.size(), 2);
            if (outs.size() == 2) begin
                check("b2b_out0", outs[0], 4'hA);
                check("b2b_out1", outs[1], 4'h5);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
